// File: rtl/game_sequencer.sv
// Run controller for the runner game: idle/countdown/play/over sequencing and game-logic reset.
// Latency: all outputs registered, one cycle after the triggering input or new_frame pulse.
// Backpressure: none; buttons are edge-detected and per-frame actions are latched on new_frame.
module game_sequencer #(
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int OVER_HOLD_FRAMES = 120,
    parameter int SCORE_SHIFT      = 12,
    parameter int GRAVITY_BASE     = 1,
    parameter int JUMP_BASE        = 190,
    parameter int JUMP_STEP        = 8,
    parameter int DUCK_BASE        = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic        btn_start,
    input  logic        btn_duck,
    input  logic        btn_jump,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        game_over_in,
    input  logic [15:0] player_score_in,
    output logic        logic_rst,
    output logic [1:0]  state,
    output logic [2:0]  level,
    output logic [3:0]  speed,
    output logic [5:0]  gravity,
    output logic [7:0]  duck_limit,
    output logic [9:0]  vertical_jump,
    output logic        duck,
    output logic        jump,
    output logic        left,
    output logic        right,
    output logic [7:0]  countdown,
    output logic [15:0] high_score
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_PLAY      = 2'd2,
        S_OVER      = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        lrst_q;
    logic [15:0] hs_q;
    logic [2:0]  level_q, level_d;
    logic [3:0]  speed_q;
    logic [5:0]  gravity_q;
    logic [7:0]  duck_limit_q;
    logic [9:0]  vjump_q;
    logic [4:0]  prev_q;
    // action bit order: [0] duck, [1] jump, [2] left, [3] right
    logic [3:0]  act_q, pend_q;

    logic [4:0]  btn_vec, press;
    logic [3:0]  act_press, act_req;
    logic        start_press;
    logic [15:0] score_sh;
    logic [2:0]  score_lvl;

    function automatic logic [3:0] speed_of(input logic [2:0] l);
        if (l < 3'd2)      return 4'd1;
        else if (l < 3'd4) return 4'd2;
        else               return 4'd4;
    endfunction

    function automatic logic [5:0] gravity_of(input logic [2:0] l);
        return 6'(GRAVITY_BASE + int'(l));
    endfunction

    function automatic logic [9:0] vjump_of(input logic [2:0] l);
        return 10'(JUMP_BASE + int'(l) * JUMP_STEP);
    endfunction

    function automatic logic [7:0] duck_of(input logic [2:0] l);
        int d;
        d = DUCK_BASE - 2 * int'(l);
        if (d < 4) d = 4;
        return 8'(d);
    endfunction

    // Button edges, target level, and the resolved per-frame action request
    always_comb begin
        btn_vec     = {btn_right, btn_left, btn_jump, btn_duck, btn_start};
        press       = btn_vec & ~prev_q;
        start_press = press[0];
        act_press   = press[4:1];
        act_req     = pend_q | act_press;
        score_sh    = player_score_in >> SCORE_SHIFT;
        score_lvl   = (score_sh > 16'd7) ? 3'd7 : score_sh[2:0];
        level_d     = level_q;
        case (state_q)
            S_IDLE, S_COUNTDOWN: level_d = 3'd0;
            S_PLAY:  if (new_frame && !game_over_in) level_d = score_lvl;
            S_OVER:  if (start_press && cnt_q == 8'd0) level_d = 3'd0;
            default: level_d = level_q;
        endcase
    end

    // Previous button levels; all ones at reset so held buttons need a re-press
    always_ff @(posedge clk) begin
        if (rst) prev_q <= '1;
        else     prev_q <= btn_vec;
    end

    // Run-state sequencing, frame counter, game-logic reset and high score
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            lrst_q  <= 1'b1;
            hs_q    <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    lrst_q <= 1'b1;
                    if (start_press) begin
                        state_q <= S_COUNTDOWN;
                        cnt_q   <= 8'(COUNTDOWN_FRAMES);
                    end
                end
                S_COUNTDOWN: begin
                    lrst_q <= 1'b1;
                    if (new_frame) begin
                        if (cnt_q == 8'd1) begin
                            state_q <= S_PLAY;
                            cnt_q   <= 8'd0;
                            lrst_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    lrst_q <= 1'b0;
                    if (game_over_in) begin
                        state_q <= S_OVER;
                        cnt_q   <= 8'(OVER_HOLD_FRAMES);
                        if (player_score_in > hs_q) hs_q <= player_score_in;
                    end
                end
                S_OVER: begin
                    // game logic stays out of reset so the final score remains visible
                    lrst_q <= 1'b0;
                    if (start_press && cnt_q == 8'd0) begin
                        state_q <= S_COUNTDOWN;
                        cnt_q   <= 8'(COUNTDOWN_FRAMES);
                        lrst_q  <= 1'b1;
                    end else if (new_frame && cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Level and difficulty settings, updated together from the next level
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q      <= 3'd0;
            speed_q      <= speed_of(3'd0);
            gravity_q    <= gravity_of(3'd0);
            duck_limit_q <= duck_of(3'd0);
            vjump_q      <= vjump_of(3'd0);
        end else begin
            level_q      <= level_d;
            speed_q      <= speed_of(level_d);
            gravity_q    <= gravity_of(level_d);
            duck_limit_q <= duck_of(level_d);
            vjump_q      <= vjump_of(level_d);
        end
    end

    // Collect presses during a frame, publish them on new_frame; left+right cancel
    always_ff @(posedge clk) begin
        if (rst || state_q != S_PLAY || game_over_in) begin
            act_q  <= 4'd0;
            pend_q <= 4'd0;
        end else if (new_frame) begin
            act_q  <= {act_req[3] & ~act_req[2], act_req[2] & ~act_req[3], act_req[1], act_req[0]};
            pend_q <= 4'd0;
        end else begin
            pend_q <= pend_q | act_press;
        end
    end

    assign state         = state_q;
    assign countdown     = cnt_q;
    assign logic_rst     = lrst_q;
    assign high_score    = hs_q;
    assign level         = level_q;
    assign speed         = speed_q;
    assign gravity       = gravity_q;
    assign duck_limit    = duck_limit_q;
    assign vertical_jump = vjump_q;
    assign duck          = act_q[0];
    assign jump          = act_q[1];
    assign left          = act_q[2];
    assign right         = act_q[3];

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a FIFO scoreboard of expected values.
// Inputs are driven 1 time unit after the rising edge; outputs sampled at the same point.
// Every expectation is queued before its stimulus and popped when the output is sampled.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst, new_frame;
    logic        btn_start, btn_duck, btn_jump, btn_left, btn_right;
    logic        game_over_in;
    logic [15:0] player_score_in;
    logic        logic_rst;
    logic [1:0]  state;
    logic [2:0]  level;
    logic [3:0]  speed;
    logic [5:0]  gravity;
    logic [7:0]  duck_limit;
    logic [9:0]  vertical_jump;
    logic        duck, jump, left, right;
    logic [7:0]  countdown;
    logic [15:0] high_score;

    int errors = 0;
    int checks = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk(clk), .rst(rst), .new_frame(new_frame),
        .btn_start(btn_start), .btn_duck(btn_duck), .btn_jump(btn_jump),
        .btn_left(btn_left), .btn_right(btn_right),
        .game_over_in(game_over_in), .player_score_in(player_score_in),
        .logic_rst(logic_rst), .state(state), .level(level), .speed(speed),
        .gravity(gravity), .duck_limit(duck_limit), .vertical_jump(vertical_jump),
        .duck(duck), .jump(jump), .left(left), .right(right),
        .countdown(countdown), .high_score(high_score)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        repeat (3) tick();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_out(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic expect_diff(input string tag, input int lvl, input int spd,
                               input int grav, input int vj, input int dl);
        expect_val({tag, "_level"}, 32'(lvl));
        expect_val({tag, "_speed"}, 32'(spd));
        expect_val({tag, "_gravity"}, 32'(grav));
        expect_val({tag, "_vjump"}, 32'(vj));
        expect_val({tag, "_duck_limit"}, 32'(dl));
    endtask

    task automatic check_diff();
        check_out(32'(level));
        check_out(32'(speed));
        check_out(32'(gravity));
        check_out(32'(vertical_jump));
        check_out(32'(duck_limit));
    endtask

    function automatic logic [31:0] acts();
        return {28'd0, duck, jump, left, right};
    endfunction

    function automatic logic [31:0] ctl();
        return {21'd0, state, logic_rst, countdown};
    endfunction

    initial begin
        rst = 1'b1; new_frame = 1'b0; game_over_in = 1'b0; player_score_in = 16'd0;
        btn_start = 1'b0; btn_duck = 1'b0; btn_jump = 1'b0; btn_left = 1'b0; btn_right = 1'b0;

        // reset values
        expect_val("rst_ctl", {21'd0, 2'd0, 1'b1, 8'd0});
        expect_val("rst_high_score", 32'd0);
        expect_val("rst_actions", 32'd0);
        expect_diff("rst", 0, 1, 1, 190, 20);
        tick(); tick();
        check_out(ctl());
        check_out(32'(high_score));
        check_out(acts());
        check_diff();

        // start held through reset must not register
        btn_start = 1'b1;
        tick();
        rst = 1'b0;
        expect_val("held_start_idle", 32'd0);
        repeat (3) tick();
        check_out(32'(state));

        // release then press: countdown begins
        btn_start = 1'b0;
        tick();
        btn_start = 1'b1;
        expect_val("start_to_countdown", {21'd0, 2'd1, 1'b1, 8'd180});
        tick();
        btn_start = 1'b0;
        check_out(ctl());

        // 180 frames of countdown; play exactly one cycle after the last pulse
        for (int i = 1; i <= 179; i++) begin
            expect_val("countdown_run", {21'd0, 2'd1, 1'b1, 8'(180 - i)});
            frame();
            check_out(ctl());
        end
        expect_val("countdown_done", {21'd0, 2'd2, 1'b0, 8'd0});
        frame();
        check_out(ctl());

        // jump pressed long before the frame shows for exactly that frame
        btn_jump = 1'b1;
        tick();
        btn_jump = 1'b0;
        repeat (499) tick();
        expect_val("jump_latched", 32'b0100);
        expect_val("jump_held_midframe", 32'b0100);
        expect_val("jump_next_frame", 32'b0000);
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        check_out(acts());
        repeat (10) tick();
        check_out(acts());
        frame();
        check_out(acts());

        // press coincident with new_frame counts for that frame
        expect_val("jump_same_cycle", 32'b0100);
        btn_jump = 1'b1;
        new_frame = 1'b1;
        tick();
        btn_jump = 1'b0;
        new_frame = 1'b0;
        check_out(acts());

        // left and right in one frame cancel
        expect_val("left_right_conflict", 32'b0000);
        btn_left = 1'b1; tick(); btn_left = 1'b0;
        btn_right = 1'b1; tick(); btn_right = 1'b0;
        frame();
        check_out(acts());

        // left alone
        expect_val("left_alone", 32'b0010);
        btn_left = 1'b1; tick(); btn_left = 1'b0;
        frame();
        check_out(acts());

        // duck and jump together both pass through
        expect_val("duck_and_jump", 32'b1100);
        btn_duck = 1'b1; btn_jump = 1'b1; tick(); btn_duck = 1'b0; btn_jump = 1'b0;
        frame();
        check_out(acts());

        // difficulty at level 2
        player_score_in = 16'h2000;
        expect_diff("lvl2", 2, 2, 3, 206, 16);
        frame();
        check_diff();

        // score changes mid-frame do not move the level
        player_score_in = 16'hF000;
        expect_val("level_stable_midframe", 32'd2);
        repeat (5) tick();
        check_out(32'(level));

        // saturated level 7
        expect_diff("lvl7", 7, 4, 8, 246, 6);
        frame();
        check_diff();

        // first game over sets the high score
        player_score_in = 16'h1000;
        game_over_in = 1'b1;
        expect_val("over1_ctl", {21'd0, 2'd3, 1'b0, 8'd120});
        expect_val("over1_high_score", 32'h1000);
        tick();
        game_over_in = 1'b0;
        check_out(ctl());
        check_out(32'(high_score));

        // start ignored during the hold
        expect_val("over_start_ignored_early", 32'd3);
        btn_start = 1'b1; tick(); btn_start = 1'b0; tick();
        check_out(32'(state));
        expect_val("over_hold_remaining", {21'd0, 2'd3, 1'b0, 8'd1});
        run_frames(119);
        check_out(ctl());
        expect_val("over_start_ignored_last", 32'd3);
        btn_start = 1'b1; tick(); btn_start = 1'b0; tick();
        check_out(32'(state));
        expect_val("over_hold_zero", 32'd0);
        frame();
        check_out(32'(countdown));
        expect_val("over_hold_saturate", 32'd0);
        frame();
        check_out(32'(countdown));

        // start accepted after the hold
        expect_val("restart_ctl", {21'd0, 2'd1, 1'b1, 8'd180});
        expect_diff("restart", 0, 1, 1, 190, 20);
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        check_out(ctl());
        check_diff();

        // second game, ending on a game over coincident with new_frame
        player_score_in = 16'h0000;
        expect_val("play2_entered", 32'd2);
        run_frames(180);
        check_out(32'(state));
        expect_val("play2_jump", 32'b0100);
        btn_jump = 1'b1; tick(); btn_jump = 1'b0;
        frame();
        check_out(acts());
        btn_jump = 1'b1; tick(); btn_jump = 1'b0;
        player_score_in = 16'h1234;
        expect_val("over2_state", 32'd3);
        expect_val("over2_actions_cleared", 32'd0);
        expect_val("over2_level_unchanged", 32'd0);
        expect_val("over2_high_score", 32'h1234);
        game_over_in = 1'b1;
        new_frame = 1'b1;
        tick();
        game_over_in = 1'b0;
        new_frame = 1'b0;
        check_out(32'(state));
        check_out(acts());
        check_out(32'(level));
        check_out(32'(high_score));

        // third game with a lower score keeps the high score
        run_frames(120);
        expect_val("restart3_state", 32'd1);
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        check_out(32'(state));
        run_frames(180);
        player_score_in = 16'h0100;
        game_over_in = 1'b1;
        expect_val("over3_state", 32'd3);
        expect_val("over3_high_score_kept", 32'h1234);
        tick();
        game_over_in = 1'b0;
        check_out(32'(state));
        check_out(32'(high_score));

        // reset from a running session clears everything
        rst = 1'b1;
        expect_val("rst2_ctl", {21'd0, 2'd0, 1'b1, 8'd0});
        expect_val("rst2_high_score", 32'd0);
        tick();
        rst = 1'b0;
        check_out(ctl());
        check_out(32'(high_score));

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level run controller for the runner game logic.
- Sequences the game through idle, countdown, play and game-over states, and drives the game logic's synchronous reset.
- Converts raw button levels into per-frame action requests that are held stable for a whole frame.
- Schedules difficulty (speed, gravity, duck limit, jump strength) from the running score, and tracks the session high score.

Parameters:
- COUNTDOWN_FRAMES, 180: frames spent in countdown before play starts (1..255).
- OVER_HOLD_FRAMES, 120: frames after game over during which start is ignored (1..255).
- SCORE_SHIFT, 12: level = player_score >> SCORE_SHIFT, saturated at 7.
- GRAVITY_BASE, 1: gravity at level 0.
- JUMP_BASE, 190: vertical_jump at level 0.
- JUMP_STEP, 8: vertical_jump increment per level.
- DUCK_BASE, 20: duck_limit at level 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- new_frame  in  1  one-cycle pulse at frame start
- btn_start, btn_duck, btn_jump, btn_left, btn_right  in  1 each  synchronized button levels
- game_over_in  in  1  game over flag from game logic
- player_score_in  in  16  score from game logic
- logic_rst  out  1  reset to game logic
- state  out  2  IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3
- level  out  3  difficulty level
- speed  out  4  difficulty setting to game logic
- gravity  out  6  difficulty setting to game logic
- duck_limit  out  8  difficulty setting to game logic
- vertical_jump  out  10  difficulty setting to game logic
- duck, jump, left, right  out  1 each  per-frame action requests
- countdown  out  8  frames remaining in COUNTDOWN / OVER hold
- high_score  out  16  best score since reset

Behaviour:
- Reset values:
  - state=IDLE, logic_rst=1, level=0, countdown=0, high_score=0.
  - duck/jump/left/right=0, pending bits=0.
  - Difficulty outputs at level-0 values.
  - Previous-button registers reset to all ones, so a button held through reset must be released and re-pressed before it registers.
- Edge detect: press = btn & ~prev, with prev registered every cycle.
- Action latching:
  - A press of duck/jump/left/right sets its pending bit.
  - On new_frame in PLAY: each action output <= pending | press (a press coincident with new_frame counts for the new frame), then pending <= 0.
  - Outputs hold constant until the next new_frame.
  - If left and right would both be set, both outputs are 0.
  - duck and jump may both be 1; the game logic resolves priority.
  - Outside PLAY: action outputs and pending are forced to 0.
- IDLE:
  - logic_rst=1.
  - A btn_start press moves to COUNTDOWN next cycle, with countdown=COUNTDOWN_FRAMES.
- COUNTDOWN:
  - logic_rst=1, level=0.
  - countdown decrements on each new_frame.
  - On the new_frame where countdown==1: go to PLAY and set countdown=0. logic_rst deasserts in the same registered update, i.e. 1 cycle after that new_frame.
- PLAY:
  - logic_rst=0.
  - On new_frame: level <= min(player_score_in >> SCORE_SHIFT, 7), and difficulty outputs update from the new level. They change only on new_frame, never mid-frame.
  - When game_over_in is sampled high: go to OVER, set countdown=OVER_HOLD_FRAMES, and high_score <= max(high_score, player_score_in) in the same cycle.
  - If game_over_in and new_frame coincide, game over wins: actions are cleared and level is unchanged.
- OVER:
  - logic_rst=0, so game-logic score and height stay visible.
  - countdown decrements on new_frame, saturating at 0.
  - btn_start is ignored while countdown != 0.
  - A start press with countdown==0 moves to COUNTDOWN (logic_rst=1, countdown=COUNTDOWN_FRAMES, level=0).
- Difficulty table (combinational from level, registered outputs):
  - speed = 1 for level 0–1, 2 for level 2–3, 4 for level 4–7. Speed always divides 32.
  - gravity = GRAVITY_BASE + level.
  - vertical_jump = JUMP_BASE + level*JUMP_STEP.
  - duck_limit = DUCK_BASE − 2*level, saturating at minimum 4.
- rst asserted in any state returns to the reset values on the next edge. This includes mid-PLAY, and high_score is cleared.

Test Plan:
- Countdown start: reset, release buttons, pulse btn_start, run 180 new_frames -> state=1 for 180 frames, logic_rst=1 throughout, state=2 and logic_rst=0 exactly 1 cycle after the 180th pulse.
- Button held through reset: hold btn_start high across reset -> stays IDLE; release then press -> COUNTDOWN.
- Jump latching: in PLAY, pulse btn_jump 500 cycles before new_frame -> jump=1 for exactly that frame, 0 the following frame. A press on the same cycle as new_frame appears in that frame.
- Left/right conflict: in PLAY, press left and right within one frame -> left=0, right=0. Left alone -> left=1.
- Difficulty: feed player_score_in=0x2000 then new_frame -> level=2, speed=2, gravity=3, vertical_jump=206, duck_limit=16. Score 0xF000 -> level=7, speed=4, duck_limit=6.
- Game over: game_over_in=1 with score 0x1234 and high_score=0x1000 -> state=3, high_score=0x1234. Start is ignored for 120 frames and accepted after -> COUNTDOWN with logic_rst=1. A later game over at score 0x0100 leaves high_score=0x1234.
